// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the dCPU decode stage: opcodes, ALU codes,
// operand selects, halt FSM states and the decoded-field bundle.
package decode_stage_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] IR_EBREAK = 32'h0010_0073;

   typedef enum logic [5:0] {
      ALU_ADD = 6'd0, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
      ALU_SB, ALU_SH, ALU_SW,
      ALU_JAL, ALU_JALR,
      ALU_NOP = 6'd63
   } alu_e;

   typedef enum logic [1:0] {
      OP_TYPE_NONE = 2'd0,
      OP_TYPE_REG  = 2'd1,
      OP_TYPE_IMM  = 2'd2,
      OP_TYPE_PC   = 2'd3
   } op_type_e;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_HALT_PEND = 2'd1,
      ST_HALTED    = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0]  srcreg1_num;
      logic [4:0]  srcreg2_num;
      logic [4:0]  dstreg_num;
      logic [31:0] imm;
      alu_e        alucode;
      op_type_e    aluop1_type;
      op_type_e    aluop2_type;
      logic        reg_we;
      logic        is_load;
      logic        is_store;
      logic        is_halt;
      logic        illegal;
   } dec_t;

   // funct3 mapping shared by OP and OP-IMM when funct7 selects the base ops
   function automatic alu_e base_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic alu_e mext_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_MUL;
         3'b001:  return ALU_MULH;
         3'b010:  return ALU_MULHSU;
         3'b011:  return ALU_MULHU;
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         default: return ALU_REMU;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded-field bus of the decode stage.
interface decode_stage_if;
   import decode_stage_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_ir;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  srcreg1_num;
   logic [4:0]  srcreg2_num;
   logic [4:0]  dstreg_num;
   logic [31:0] imm;
   alu_e        alucode;
   op_type_e    aluop1_type;
   op_type_e    aluop2_type;
   logic        reg_we;
   logic        is_load;
   logic        is_store;
   logic        is_halt;
   logic        illegal;

   // master: the surrounding pipeline (fetch drives in_*, execute drives out_ready)
   modport master (
      output in_valid, in_ir, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, srcreg1_num, srcreg2_num, dstreg_num,
             imm, alucode, aluop1_type, aluop2_type, reg_we, is_load, is_store,
             is_halt, illegal
   );

   modport slave (
      input  in_valid, in_ir, in_pc, out_ready,
      output in_ready, out_valid, out_pc, srcreg1_num, srcreg2_num, dstreg_num,
             imm, alucode, aluop1_type, aluop2_type, reg_we, is_load, is_store,
             is_halt, illegal
   );
endinterface

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I(/M) decoder: instruction word -> decoded fields.
module decode_comb
   import decode_stage_pkg::*;
#(
   parameter bit ENABLE_M = ENABLE
) (
   input  logic [31:0] i_ir,
   output dec_t        o_dec
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_shamt;
   logic        w_bad;

   assign w_opc   = i_ir[6:0];
   assign w_rd    = i_ir[11:7];
   assign w_f3    = i_ir[14:12];
   assign w_rs1   = i_ir[19:15];
   assign w_rs2   = i_ir[24:20];
   assign w_f7    = i_ir[31:25];
   assign w_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
   assign w_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
   assign w_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
   assign w_imm_u = {i_ir[31:12], 12'b0};
   assign w_imm_j = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
   assign w_shamt = {27'b0, i_ir[24:20]};

   always_comb begin
      o_dec         = '0;
      o_dec.alucode = ALU_NOP;
      w_bad         = 1'b0;

      case (w_opc)
         OPC_LUI: begin
            o_dec.dstreg_num  = w_rd;
            o_dec.imm         = w_imm_u;
            o_dec.alucode     = ALU_ADD;
            o_dec.aluop1_type = OP_TYPE_NONE;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.reg_we      = 1'b1;
         end
         OPC_AUIPC: begin
            o_dec.dstreg_num  = w_rd;
            o_dec.imm         = w_imm_u;
            o_dec.alucode     = ALU_ADD;
            o_dec.aluop1_type = OP_TYPE_PC;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.reg_we      = 1'b1;
         end
         OPC_JAL: begin
            o_dec.dstreg_num  = w_rd;
            o_dec.imm         = w_imm_j;
            o_dec.alucode     = ALU_JAL;
            o_dec.aluop1_type = OP_TYPE_PC;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.reg_we      = 1'b1;
         end
         OPC_JALR: begin
            o_dec.srcreg1_num = w_rs1;
            o_dec.dstreg_num  = w_rd;
            o_dec.imm         = w_imm_i;
            o_dec.alucode     = ALU_JALR;
            o_dec.aluop1_type = OP_TYPE_REG;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.reg_we      = 1'b1;
            w_bad             = (w_f3 != 3'b000);
         end
         OPC_BRANCH: begin
            o_dec.srcreg1_num = w_rs1;
            o_dec.srcreg2_num = w_rs2;
            o_dec.imm         = w_imm_b;
            o_dec.aluop1_type = OP_TYPE_PC;
            o_dec.aluop2_type = OP_TYPE_IMM;
            case (w_f3)
               3'b000:  o_dec.alucode = ALU_BEQ;
               3'b001:  o_dec.alucode = ALU_BNE;
               3'b100:  o_dec.alucode = ALU_BLT;
               3'b101:  o_dec.alucode = ALU_BGE;
               3'b110:  o_dec.alucode = ALU_BLTU;
               3'b111:  o_dec.alucode = ALU_BGEU;
               default: w_bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            o_dec.srcreg1_num = w_rs1;
            o_dec.dstreg_num  = w_rd;
            o_dec.imm         = w_imm_i;
            o_dec.aluop1_type = OP_TYPE_REG;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.reg_we      = 1'b1;
            o_dec.is_load     = 1'b1;
            case (w_f3)
               3'b000:  o_dec.alucode = ALU_LB;
               3'b001:  o_dec.alucode = ALU_LH;
               3'b010:  o_dec.alucode = ALU_LW;
               3'b100:  o_dec.alucode = ALU_LBU;
               3'b101:  o_dec.alucode = ALU_LHU;
               default: w_bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            o_dec.srcreg1_num = w_rs1;
            o_dec.srcreg2_num = w_rs2;
            o_dec.imm         = w_imm_s;
            o_dec.aluop1_type = OP_TYPE_REG;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.is_store    = 1'b1;
            case (w_f3)
               3'b000:  o_dec.alucode = ALU_SB;
               3'b001:  o_dec.alucode = ALU_SH;
               3'b010:  o_dec.alucode = ALU_SW;
               default: w_bad = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            o_dec.srcreg1_num = w_rs1;
            o_dec.dstreg_num  = w_rd;
            o_dec.imm         = w_imm_i;
            o_dec.aluop1_type = OP_TYPE_REG;
            o_dec.aluop2_type = OP_TYPE_IMM;
            o_dec.reg_we      = 1'b1;
            o_dec.alucode     = base_alu(w_f3);
            // shifts carry a 5-bit shamt; the upper immediate bits must be a valid funct7
            if (w_f3 == 3'b001) begin
               o_dec.imm = w_shamt;
               w_bad     = (w_f7 != 7'b0000000);
            end else if (w_f3 == 3'b101) begin
               o_dec.imm = w_shamt;
               if (w_f7 == 7'b0100000) o_dec.alucode = ALU_SRA;
               else if (w_f7 != 7'b0000000) w_bad = 1'b1;
            end
         end
         OPC_OP: begin
            o_dec.srcreg1_num = w_rs1;
            o_dec.srcreg2_num = w_rs2;
            o_dec.dstreg_num  = w_rd;
            o_dec.aluop1_type = OP_TYPE_REG;
            o_dec.aluop2_type = OP_TYPE_REG;
            o_dec.reg_we      = 1'b1;
            case (w_f7)
               7'b0000000: o_dec.alucode = base_alu(w_f3);
               7'b0100000: begin
                  if (w_f3 == 3'b000)      o_dec.alucode = ALU_SUB;
                  else if (w_f3 == 3'b101) o_dec.alucode = ALU_SRA;
                  else                     w_bad = 1'b1;
               end
               7'b0000001: begin
                  if (ENABLE_M != DISABLE) o_dec.alucode = mext_alu(w_f3);
                  else                     w_bad = 1'b1;
               end
               default: w_bad = 1'b1;
            endcase
         end
         OPC_MISCMEM: w_bad = (w_f3 != 3'b000);
         OPC_SYSTEM: begin
            if ((i_ir == IR_ECALL) || (i_ir == IR_EBREAK)) o_dec.is_halt = 1'b1;
            else                                          w_bad = 1'b1;
         end
         default: w_bad = 1'b1;
      endcase

      if (w_bad) begin
         o_dec.illegal  = 1'b1;
         o_dec.alucode  = ALU_NOP;
         o_dec.reg_we   = 1'b0;
         o_dec.is_load  = 1'b0;
         o_dec.is_store = 1'b0;
      end
      if (o_dec.dstreg_num == 5'd0) o_dec.reg_we = 1'b0;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register with valid/ready handshake,
// ECALL/EBREAK halt FSM and a saturating consumed-instruction counter.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter bit ENABLE_M = ENABLE,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   decode_stage_if.slave    bus,
   output logic             halted,
   output logic [CNT_W-1:0] decoded_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_valid;
   dec_t             r_dec;
   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_count;
   dec_t             w_dec;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_consume;

   decode_comb #(.ENABLE_M(ENABLE_M)) u_comb (
      .i_ir  (bus.in_ir),
      .o_dec (w_dec)
   );

   // no skid buffer: a new word is taken only when the held one leaves this cycle
   assign w_in_ready = (r_state == ST_RUN) && !flush && (!r_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_consume  = r_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:       if (w_accept && w_dec.is_halt) w_state_nxt = ST_HALT_PEND;
         ST_HALT_PEND: begin
            if (flush)          w_state_nxt = ST_RUN;
            else if (w_consume) w_state_nxt = ST_HALTED;
         end
         ST_HALTED:    w_state_nxt = ST_HALTED;
         default:      w_state_nxt = ST_RUN;
      endcase
   end

   // decode -> execute boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_dec   <= '0;
         r_pc    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_dec   <= w_dec;
         r_pc    <= bus.in_pc;
      end else if (w_consume) begin
         r_valid <= 1'b0;
      end
   end

   // a consume that coincides with flush is discarded and not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_consume && !flush && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_ONE;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_valid;
   assign bus.out_pc      = r_pc;
   assign bus.srcreg1_num = r_dec.srcreg1_num;
   assign bus.srcreg2_num = r_dec.srcreg2_num;
   assign bus.dstreg_num  = r_dec.dstreg_num;
   assign bus.imm         = r_dec.imm;
   assign bus.alucode     = r_dec.alucode;
   assign bus.aluop1_type = r_dec.aluop1_type;
   assign bus.aluop2_type = r_dec.aluop2_type;
   assign bus.reg_we      = r_dec.reg_we;
   assign bus.is_load     = r_dec.is_load;
   assign bus.is_store    = r_dec.is_store;
   assign bus.is_halt     = r_dec.is_halt;
   assign bus.illegal     = r_dec.illegal;
   assign halted          = (r_state == ST_HALTED);
   assign decoded_count   = r_count;

endmodule
